// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Brin, one bit per clock, LSB first.
// One full-subtractor stage plus a borrow flip-flop; start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             brin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             brout,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nx;
  logic [CNT_W-1:0] cnt;
  logic             bor, a_msb, b_msb;
  logic             diff, borrow, last, accept;

  always_comb begin
    diff   = a_sh[0] ^ b_sh[0] ^ bor;
    borrow = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bor);
    // Shift right so the new bit lands in the MSB; also valid for WIDTH==1.
    r_nx            = r_sh >> 1;
    r_nx[WIDTH-1]   = diff;
    last   = (cnt == CNT_W'(WIDTH - 1));
    accept = start && ((state == IDLE) || (state == DONE));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      cnt   <= '0;
      bor   <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      d     <= '0;
      brout <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      bor   <= brin;
      cnt   <= '0;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      r_sh <= r_nx;
      bor  <= borrow;
      cnt  <= cnt + CNT_W'(1);
      // Results are published only on the final bit, never partially.
      if (last) begin
        d     <= r_nx;
        brout <= borrow;
        ovf   <= (a_msb != b_msb) && (diff != a_msb);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: one 1-bit and one 8-bit instance.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, brin1, busy1, done1, brout1, ovf1;
  logic [0:0] a1, b1, d1;
  logic       start8, brin8, busy8, done8, brout8, ovf8;
  logic [7:0] a8, b8, d8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .brin(brin1),
    .busy(busy1), .done(done1), .d(d1), .brout(brout1), .ovf(ovf1)
  );

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .brin(brin8),
    .busy(busy8), .done(done8), .d(d8), .brout(brout8), .ovf(ovf8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until done8 is seen (bounded); reports cycles taken and busy samples.
  task automatic wait_done8(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (n < 20) begin
      if (busy8) nbusy++;
      step();
      n++;
      if (done8) return;
    end
    n = 99;
  endtask

  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    a8 = a; b8 = b; brin8 = c; start8 = 1'b1;
    step();
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; brin8 = ~c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; brin1 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; brin8 = 1'b0;
    step(); step();
    checks++;
    if ({busy8, done8, d8, brout8, ovf8} !== 12'h0) begin
      errors++;
      $display("FAIL reset8 got busy=%b done=%b d=%h brout=%b ovf=%b want all 0",
               busy8, done8, d8, brout8, ovf8);
    end
    checks++;
    if ({busy1, done1, d1, brout1, ovf1} !== 5'b0) begin
      errors++;
      $display("FAIL reset1 got busy=%b done=%b d=%b brout=%b ovf=%b want all 0",
               busy1, done1, d1, brout1, ovf1);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_width1();
    // {brout,d,ovf} for index {a,b,brin}
    logic [2:0] exp1 [8] = '{3'b000, 3'b110, 3'b111, 3'b100,
                             3'b010, 3'b001, 3'b000, 3'b110};
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; brin1 = v[0]; start1 = 1'b1;
      step();
      start1 = 1'b0;
      checks++;
      if (busy1 !== 1'b1) begin
        errors++;
        $display("FAIL w1_busy idx=%0d got %b want 1", i, busy1);
      end
      step();
      checks++;
      if ({done1, brout1, d1, ovf1} !== {1'b1, exp1[i]}) begin
        errors++;
        $display("FAIL w1_result idx=%0d got done=%b brout=%b d=%b ovf=%b want done=1 {brout,d,ovf}=%b",
                 i, done1, brout1, d1, ovf1, exp1[i]);
      end
      step();
    end
  endtask

  task automatic test_basic();
    int n, nb;
    start_op8(8'h05, 8'h03, 1'b0);
    wait_done8(n, nb);
    checks++;
    if (n != 8 || nb != 8) begin
      errors++;
      $display("FAIL basic_latency got cycles=%0d busy=%0d want 8/8", n, nb);
    end
    checks++;
    if ({d8, brout8, ovf8} !== {8'h02, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_result got d=%h brout=%b ovf=%b want 02 0 0", d8, brout8, ovf8);
    end
    step();
    checks++;
    if (done8 !== 1'b0 || d8 !== 8'h02) begin
      errors++;
      $display("FAIL basic_hold got done=%b d=%h want 0 02", done8, d8);
    end
  endtask

  task automatic test_borrow_ovf();
    int n, nb;
    start_op8(8'h00, 8'h01, 1'b0);
    wait_done8(n, nb);
    checks++;
    if (n != 8 || {d8, brout8, ovf8} !== {8'hFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL underflow got n=%0d d=%h brout=%b ovf=%b want 8 FF 1 0", n, d8, brout8, ovf8);
    end
    step();
    start_op8(8'h80, 8'h01, 1'b0);
    wait_done8(n, nb);
    checks++;
    if (n != 8 || {d8, brout8, ovf8} !== {8'h7F, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL signed_ovf got n=%0d d=%h brout=%b ovf=%b want 8 7F 0 1", n, d8, brout8, ovf8);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int n, nb;
    a8 = 8'h10; b8 = 8'h0F; brin8 = 1'b1; start8 = 1'b1;
    step();
    a8 = 8'h7F; b8 = 8'hFF; brin8 = 1'b0;
    wait_done8(n, nb);
    checks++;
    if (n != 8 || {d8, brout8, ovf8} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_first got n=%0d d=%h brout=%b ovf=%b want 8 00 0 0", n, d8, brout8, ovf8);
    end
    step();
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart got busy=%b want 1", busy8);
    end
    wait_done8(n, nb);
    checks++;
    if (n != 8 || {d8, brout8, ovf8} !== {8'h80, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_second got n=%0d d=%h brout=%b ovf=%b want 8 80 1 1", n, d8, brout8, ovf8);
    end
    step(); step();
  endtask

  task automatic test_start_in_run();
    int ndone;
    ndone = 0;
    start_op8(8'h05, 8'h03, 1'b0);
    for (int i = 0; i < 14; i++) begin
      if (i == 3) begin
        a8 = 8'hFF; b8 = 8'h00; brin8 = 1'b1; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      step();
      if (done8) ndone++;
    end
    checks++;
    if (ndone != 1 || d8 !== 8'h02 || brout8 !== 1'b0) begin
      errors++;
      $display("FAIL start_in_run got dones=%0d d=%h brout=%b want 1 02 0", ndone, d8, brout8);
    end
  endtask

  task automatic test_reset_mid_run();
    int ndone, n, nb;
    start_op8(8'h00, 8'h01, 1'b0);
    wait_done8(n, nb);
    step();
    start_op8(8'h05, 8'h03, 1'b0);
    step(); step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({busy8, done8, d8, brout8, ovf8} !== 12'h0) begin
      errors++;
      $display("FAIL rst_mid_run got busy=%b done=%b d=%h brout=%b ovf=%b want all 0",
               busy8, done8, d8, brout8, ovf8);
    end
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done8 || busy8) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL rst_no_done got activity=%0d want 0", ndone);
    end
    start_op8(8'h80, 8'h01, 1'b0);
    wait_done8(n, nb);
    checks++;
    if (n != 8 || {d8, brout8, ovf8} !== {8'h7F, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rst_fresh got n=%0d d=%h brout=%b ovf=%b want 8 7F 0 1", n, d8, brout8, ovf8);
    end
  endtask

  initial begin
    test_reset();
    test_width1();
    test_basic();
    test_borrow_ovf();
    test_back_to_back();
    test_start_in_run();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
